// File: rtl/dmem_access_unit_if.sv
// Request/response and RAM-port bundle for dmem_access_unit.
// Latency/backpressure are properties of the unit, not of this bundle.
// master = core memory stage plus RAM model side; slave = the access unit.
interface dmem_access_unit_if #(
    parameter int DATAW = 32,
    parameter int ADDRW = 32
);
    logic             req_valid;
    logic             req_ready;
    logic             req_we;
    logic [ADDRW-1:0] req_addr;
    logic [1:0]       req_size;
    logic             req_unsigned;
    logic [DATAW-1:0] req_wdata;
    logic             resp_valid;
    logic [DATAW-1:0] resp_rdata;
    logic             resp_err;
    logic             ram_wea;
    logic [ADDRW-1:0] ram_addra;
    logic [DATAW-1:0] ram_dina;
    logic [ADDRW-1:0] ram_addrb;
    logic [DATAW-1:0] ram_doutb;

    modport master (
        output req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata, ram_doutb,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  ram_wea, ram_addra, ram_dina, ram_addrb
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata, ram_doutb,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output ram_wea, ram_addra, ram_dina, ram_addrb
    );
endinterface

// File: rtl/dmem_access_unit.sv
// Byte/half/word load-store initiator for a 1-cycle-read simple dual-port RAM.
// Latency: error 1, word store 1, load 2, sub-word store (read-modify-write) 2 cycles.
// Backpressure: req_ready only in IDLE; one request in flight at a time.
module dmem_access_unit #(
    parameter int DATAW    = 32,
    parameter int ADDRW    = 32,
    parameter int WORD_LEN = 2
) (
    input  logic                clk,
    input  logic                rst,
    dmem_access_unit_if.slave   bus
);
    typedef enum logic [2:0] {IDLE, LOAD_WAIT, STORE, RMW_WAIT, RMW_WRITE} state_t;

    state_t               state, state_nxt;
    logic [ADDRW-1:0]     a_addr;
    logic [1:0]           a_size;
    logic                 a_uns;
    logic [15:0]          a_wdata;
    logic                 accept, req_err;
    logic [WORD_LEN-1:0]  req_off, a_off;
    logic [7:0]           ld_byte;
    logic [15:0]          ld_half;
    logic [DATAW-1:0]     ld_dat, mrg_dat;
    logic                 resp_v_q, resp_err_q, wea_q;
    logic [DATAW-1:0]     resp_rdata_q, dina_q;
    logic [ADDRW-1:0]     addra_q;

    assign req_off = bus.req_addr[WORD_LEN-1:0];
    assign a_off   = a_addr[WORD_LEN-1:0];
    assign accept  = bus.req_valid && bus.req_ready;

    always_comb begin
        case (bus.req_size)
            2'b00:   req_err = 1'b0;
            2'b01:   req_err = req_off[0];
            2'b10:   req_err = |req_off;
            default: req_err = 1'b1;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept && !req_err) begin
                    if (!bus.req_we)                state_nxt = LOAD_WAIT;
                    else if (bus.req_size == 2'b10) state_nxt = STORE;
                    else                            state_nxt = RMW_WAIT;
                end
            end
            RMW_WAIT: state_nxt = RMW_WRITE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Output logic; read address follows the live request in IDLE so the RAM samples it at accept
    always_comb begin
        bus.req_ready  = (state == IDLE) && !rst;
        bus.ram_addrb  = (state == IDLE) ? bus.req_addr : a_addr;
        bus.ram_wea    = wea_q && !rst;
        bus.ram_addra  = addra_q;
        bus.ram_dina   = dina_q;
        bus.resp_valid = resp_v_q && !rst;
        bus.resp_err   = resp_err_q && !rst;
        bus.resp_rdata = resp_rdata_q;
    end

    // Lane extraction and merge against the word returned on port B
    always_comb begin
        ld_byte = bus.ram_doutb[{a_off, 3'b000} +: 8];
        ld_half = bus.ram_doutb[{a_off[1], 4'b0000} +: 16];
        case (a_size)
            2'b00:   ld_dat = {{(DATAW-8){ld_byte[7] & ~a_uns}}, ld_byte};
            2'b01:   ld_dat = {{(DATAW-16){ld_half[15] & ~a_uns}}, ld_half};
            default: ld_dat = bus.ram_doutb;
        endcase
        mrg_dat = bus.ram_doutb;
        if (a_size == 2'b00) mrg_dat[{a_off, 3'b000} +: 8]     = a_wdata[7:0];
        else                 mrg_dat[{a_off[1], 4'b0000} +: 16] = a_wdata;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            a_addr  <= bus.req_addr;
            a_size  <= bus.req_size;
            a_uns   <= bus.req_unsigned;
            a_wdata <= bus.req_wdata[15:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            resp_v_q     <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
            wea_q        <= 1'b0;
            addra_q      <= '0;
            dina_q       <= '0;
        end else begin
            resp_v_q     <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
            wea_q        <= 1'b0;
            if (accept) begin
                if (req_err) begin
                    resp_v_q   <= 1'b1;
                    resp_err_q <= 1'b1;
                end else if (bus.req_we && bus.req_size == 2'b10) begin
                    wea_q    <= 1'b1;
                    addra_q  <= bus.req_addr;
                    dina_q   <= bus.req_wdata;
                    resp_v_q <= 1'b1;
                end
            end
            if (state == LOAD_WAIT) begin
                resp_v_q     <= 1'b1;
                resp_rdata_q <= ld_dat;
            end
            if (state == RMW_WAIT) begin
                wea_q    <= 1'b1;
                addra_q  <= a_addr;
                dina_q   <= mrg_dat;
                resp_v_q <= 1'b1;
            end
        end
    end
endmodule

// File: doc/dmem_access_unit.md
Name: dmem_access_unit

Overview:
- Memory-side initiator for the simple dual-port block RAM wrapper: write on port A, 1-cycle-latency read on port B, full-word writes only.
- Accepts byte, halfword and word load/store requests from the core's memory stage over a valid/ready handshake.
- Byte and halfword stores are done as read-modify-write.
- Loads return a sign- or zero-extended result over a single-cycle response pulse.

Parameters:
- DATAW, 32, data width; fixed at 32 (sub-word lane logic assumes 4 byte lanes).
- ADDRW, 32, byte-address width presented to the RAM ports.
- WORD_LEN, 2, byte-offset bits dropped by the RAM to form the word index.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request
- req_we  in  1  1 = store, 0 = load
- req_addr  in  ADDRW  byte address
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned  in  1  zero-extend load result when 1
- req_wdata  in  DATAW  store data, right-aligned
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  DATAW  load result; 0 for stores and errors
- resp_err  out  1  misaligned/illegal request, valid with resp_valid
- ram_wea  out  1  RAM port A write enable
- ram_addra  out  ADDRW  RAM port A byte address
- ram_dina  out  DATAW  RAM port A write word
- ram_addrb  out  ADDRW  RAM port B byte address
- ram_doutb  in  DATAW  RAM port B read word, valid one cycle after address sampled

Behaviour:
- States: IDLE, LOAD_WAIT, STORE, RMW_WAIT, RMW_WRITE.
- Handshake:
  - req_ready = 1 only in IDLE and not rst.
  - Accept on a clk edge with req_valid & req_ready.
  - All req_* fields are latched at accept; req_valid is ignored in other states.
- ram_addrb is combinational from req_addr in IDLE and from the latched address otherwise, so the RAM samples the read address at the accept edge.
- ram_wea, ram_addra and ram_dina are registered. ram_wea is additionally gated by !rst, so no write occurs in any cycle with rst high.
- Cycle numbering: T is the accept cycle.
- Misaligned or illegal requests (half with addr[0]=1; word with addr[1:0]≠0; size 11):
  - No RAM write.
  - T+1: resp_valid=1, resp_err=1, resp_rdata=0.
  - State stays IDLE, so req_ready=1 in T+1.
- Load:
  - T+1: LOAD_WAIT, ram_doutb valid.
  - At the T+1 edge, the lane is selected and extended into resp_rdata.
  - T+2: resp_valid=1, state IDLE.
- Word store:
  - T+1: STORE, ram_wea=1, ram_addra = latched address, ram_dina = wdata, resp_valid=1.
  - T+2: IDLE.
- Byte/half store:
  - T+1: RMW_WAIT; the old word is merged with the new lane into a register.
  - T+2: RMW_WRITE, ram_wea=1 with the merged word, resp_valid=1.
  - T+3: IDLE.
- Lane rules:
  - Little-endian; byte lane = addr[1:0], half lane = addr[1].
  - Merge replaces only the addressed 8/16 bits.
  - Sign extension from bit 7 or bit 15 unless req_unsigned.
- Hazards:
  - No read is issued while a write is pending, because req_ready=0 in STORE and RMW_WRITE.
  - The earliest next read is sampled one edge after the write commits, so back-to-back store→load to the same word returns the new data.
- Outputs:
  - resp_valid is exactly one cycle per accepted request.
  - resp_err=0 on legal requests.
  - resp_rdata=0 on stores.
- Reset:
  - state IDLE; resp_valid, resp_err, resp_rdata, ram_wea, ram_addra, ram_dina all 0.
  - A request in flight is dropped with no response. A pending RMW write is suppressed, leaving the RAM word unchanged.
- Throughput: one load or word store per 2 cycles, one sub-word store per 3 cycles, one error per cycle.

Test Plan:
- Word store 0xDEADBEEF @0x10, then word load @0x10 -> store: resp_valid at T+1, ram_wea=1 with addra=0x10 at T+1. Load: resp_valid at T+2, resp_rdata=0xDEADBEEF.
- Byte store 0xAA @0x11 over word 0x11223344, then word load @0x10 -> single write of 0x1122AA44 at T+2; load returns 0x1122AA44.
- Byte load @0x13 of word 0x80FF0000, signed then unsigned -> 0xFFFFFF80, then 0x00000080. Half load @0x12: signed -> 0xFFFF80FF, unsigned -> 0x000080FF.
- Half store @0x13 and word load @0x12 -> each gives resp_err=1, resp_rdata=0, ram_wea never asserted, req_ready stays 1.
- req_valid held high with 3 back-to-back word loads -> accepts at cycles 0, 2, 4; exactly 3 resp_valid pulses at 2, 4, 6.
- rst asserted during RMW_WRITE of a byte store to 0x20 (old 0x00000000) -> ram_wea=0 that cycle, no resp_valid, RAM word still 0x00000000, req_ready=1 the cycle after rst deasserts.
